// File: rtl/mem_pkg.sv
// mem_pkg
//   Shared definitions for the data-memory responder:
//   - state_e    : responder FSM state encoding
//   - WORD_W     : RAM word width in bits
//   - OFFS_W     : width of the byte offset inside a word
//   - addr_fault : returns 1 for a misaligned or out-of-range byte address
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int WORD_W = 32;
   localparam int OFFS_W = 2;

   // A word access is legal only when the byte offset is zero and every
   // address bit above the word index is zero.
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input int          depth_log2);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[OFFS_W-1:0] != '0);
      out_of_range = ((addr >> (depth_log2 + OFFS_W)) != 32'd0);
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// mem_array
//   Single-port synchronous RAM, 2**AW words of WORD_W bits, no reset.
//   A read happens on every enabled edge and lands in a registered output;
//   on a write edge the output register receives the old word.
//   Ports:
//     clk_i   : clock
//     en_i    : access enable (read, plus write when we_i=1)
//     we_i    : write enable
//     addr_i  : word index
//     wdata_i : write data
//     rdata_o : registered read data
module mem_array
   import mem_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [2**AW];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the CPU data port. Accepts one load/store at a
//   time (req_i && ready_o at a rising edge), waits LATENCY cycles, then
//   returns a single-cycle response on rvalid_o.
//
//   Handshake: a request is accepted on a rising edge where req_i=1 and
//   ready_o=1; we_i/addr_i/wdata_i are captured on that edge. ready_o stays
//   low until the response cycle has ended, and req_i is ignored meanwhile.
//   rvalid_o is high for exactly one cycle; rdata_o and err_o are zero
//   whenever rvalid_o is low.
//
//   Ports:
//     clk_i    : clock
//     rst_i    : asynchronous active-high reset (RAM contents survive)
//     req_i    : request valid
//     we_i     : 1 = store, 0 = load
//     addr_i   : byte address
//     wdata_i  : store data
//     ready_o  : request can be accepted this cycle
//     rvalid_o : response strobe
//     rdata_o  : load data (0 for stores and faults)
//     err_o    : access fault, qualified by rvalid_o
//     state_o  : current FSM state, for observation
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic              ready_o,
   output logic              rvalid_o,
   output logic [WORD_W-1:0] rdata_o,
   output logic              err_o,
   output state_e            state_o
);

   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              enter_resp;

   logic              ram_en;
   logic              ram_we;
   logic [DEPTH_LOG2-1:0] ram_addr;
   logic [WORD_W-1:0] ram_rdata;
   logic              fault_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               if (LATENCY == 0) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The RAM is driven from the *next* holding values so that a zero-latency
   // access, which enters RESP on its acceptance edge, sees the live request.
   // On later edges the next values equal the held ones.
   assign ram_en   = enter_resp;
   assign ram_we   = enter_resp && we_d && !addr_fault(addr_d, DEPTH_LOG2);
   assign ram_addr = addr_d[DEPTH_LOG2+OFFS_W-1:OFFS_W];

   mem_array #(
      .AW (DEPTH_LOG2)
   ) u_mem_array (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (wdata_d),
      .rdata_o (ram_rdata)
   );

   assign fault_q  = addr_fault(addr_q, DEPTH_LOG2);
   assign ready_o  = (state_q == ST_IDLE);
   assign rvalid_o = (state_q == ST_RESP);
   assign err_o    = rvalid_o && fault_q;
   assign rdata_o  = (rvalid_o && !we_q && !fault_q) ? ram_rdata : '0;
   assign state_o  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
   import mem_pkg::*;

   localparam int LAT = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT with LATENCY=2 ----------------
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        ready, rvalid, err;
   logic [31:0] rdata;
   state_e      state;

   data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .ready_o(ready), .rvalid_o(rvalid), .rdata_o(rdata),
      .err_o(err), .state_o(state)
   );

   // ---------------- DUT with LATENCY=0 ----------------
   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic        ready0, rvalid0, err0;
   logic [31:0] rdata0;
   state_e      state0;

   data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .addr_i(addr0),
      .wdata_i(wdata0), .ready_o(ready0), .rvalid_o(rvalid0), .rdata_o(rdata0),
      .err_o(err0), .state_o(state0)
   );

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Plain word array, 1 KiB address space; faults from address arithmetic.
   logic [31:0] ref_mem [256];

   function automatic logic ref_fault(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd1024);
   endfunction

   // ---------------- scoreboard ----------------
   logic [32:0] exp_q[$];   // {err, rdata}
   logic        prev_rv = 1'b0;

   always @(negedge clk) begin
      logic [32:0] e;
      if (rvalid) begin
         chk("rvalid_single_cycle", {31'd0, prev_rv}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            chk("resp_err", {31'd0, err}, {31'd0, e[32]});
            chk("resp_rdata", rdata, e[31:0]);
         end
      end else if (prev_rv) begin
         chk("err_after_resp", {31'd0, err}, 32'd0);
         chk("rdata_after_resp", rdata, 32'd0);
      end
      prev_rv = rvalid;
   end

   // ---------------- driver ----------------
   // Issues one access, returns the cycle number of its acceptance edge.
   // Expectation must already be queued by the caller.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, output int acc_cyc);
      int n;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         chk("accept_timeout", {31'd0, ready}, 32'd1);
         req = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      // Scramble the bus after acceptance; the outstanding access must not care.
      we = ~w; addr = $urandom; wdata = $urandom;
      req = hold;
      n = 0;
      while (1) begin
         @(negedge clk);
         n++;
         chk("busy_ready_low", {31'd0, ready}, 32'd0);
         if (rvalid || n >= 20) break;
      end
      chk("latency", n, LAT + 1);
   endtask

   task automatic access_model(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input bit hold, output int acc_cyc);
      logic        f;
      logic [31:0] r;
      f = ref_fault(a);
      r = (!w && !f) ? ref_mem[a / 4] : 32'd0;
      exp_q.push_back({f, r});
      if (w && !f) ref_mem[a / 4] = d;
      access(w, a, d, hold, acc_cyc);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic        e_err;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int t0, t1, t2, tdum, seen;
      logic [31:0] a, d;
      logic        w;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0};
      tbl[3]  = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
      tbl[4]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0};
      tbl[5]  = '{1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'h0};
      tbl[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5};
      tbl[7]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D};
      tbl[9]  = '{1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
      tbl[10] = '{1'b1, 32'h0000_0022, 32'h7777_7777, 1'b1, 32'h0};

      // ---- reset: asynchronous effect and hold after release ----
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_state", {30'd0, state}, {30'd0, ST_IDLE});
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_ready", {31'd0, ready}, 32'd1);
         chk("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
      end

      // ---- table-driven directed vectors ----
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back({tbl[i].e_err, tbl[i].e_rdata});
         access(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, tdum);
      end

      // ---- fill whole RAM so the model knows every word ----
      for (int i = 0; i < 256; i++) begin
         d = (i == 8) ? 32'h0F0F_F0F0 : $urandom;
         access_model(1'b1, i * 4, d, 1'b0, tdum);
      end

      // ---- back-to-back loads with req held high ----
      access_model(1'b0, 32'h0, 32'h0, 1'b1, t0);
      access_model(1'b0, 32'h4, 32'h0, 1'b1, t1);
      access_model(1'b0, 32'h8, 32'h0, 1'b1, t2);
      req = 1'b0;
      chk("b2b_gap_1", t1 - t0, LAT + 2);
      chk("b2b_gap_2", t2 - t1, LAT + 2);

      // ---- reset during WAIT aborts a store ----
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      @(negedge clk);
      chk("abort_in_wait", {30'd0, state}, {30'd0, ST_WAIT});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rvalid) seen++;
      end
      chk("abort_no_rvalid", seen, 0);
      access_model(1'b0, 32'h20, 32'h0, 1'b0, tdum);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 300; i++) begin
         w = $urandom_range(0, 1);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: a = $urandom_range(0, 255) * 4;
            7: a = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
            default: begin
               a = $urandom;
               if (a < 32'd1024) a = a + 32'd1024;
            end
         endcase
         access_model(w, a, $urandom, $urandom_range(0, 1), tdum);
      end
      req = 1'b0;
      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);

      // ---- LATENCY=0 build ----
      @(negedge clk);
      chk("l0_ready_idle", {31'd0, ready0}, 32'd1);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      @(negedge clk);
      chk("l0_st_rvalid", {31'd0, rvalid0}, 32'd1);
      chk("l0_st_err", {31'd0, err0}, 32'd0);
      chk("l0_st_rdata", rdata0, 32'd0);
      chk("l0_st_ready", {31'd0, ready0}, 32'd0);
      @(negedge clk);
      chk("l0_st_ready_back", {31'd0, ready0}, 32'd1);
      chk("l0_st_rvalid_drop", {31'd0, rvalid0}, 32'd0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      @(posedge clk);
      #1;
      req0 = 1'b0; addr0 = 32'h41;
      @(negedge clk);
      chk("l0_ld_rvalid", {31'd0, rvalid0}, 32'd1);
      chk("l0_ld_rdata", rdata0, 32'h0BAD_F00D);
      chk("l0_ld_err", {31'd0, err0}, 32'd0);
      @(negedge clk);
      chk("l0_ld_ready_back", {31'd0, ready0}, 32'd1);
      req0 = 1'b1; addr0 = 32'h41;
      @(posedge clk);
      #1;
      req0 = 1'b0;
      @(negedge clk);
      chk("l0_mis_rvalid", {31'd0, rvalid0}, 32'd1);
      chk("l0_mis_err", {31'd0, err0}, 32'd1);
      chk("l0_mis_rdata", rdata0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- global time limit ----------------
   initial begin
      #2000000;
      checks++;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined CPU's data-memory port.
- Accepts one load or store request at a time over a req/ready handshake, inserts LATENCY wait cycles, then returns a one-cycle response.
- The response carries rdata for loads, an acknowledge for stores, and an error flag for misaligned or out-of-range addresses.
- Sits between the CPU's MEM stage and a word-organised RAM; the CPU stalls its pipeline while a request is outstanding.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words in the RAM (256 words = 1 KiB).
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  1  CPU request valid.
- we  in  1  1 = store, 0 = load; sampled at acceptance.
- addr  in  32  byte address; sampled at acceptance.
- wdata  in  32  store data; sampled at acceptance.
- ready  out  1  responder can accept a request this cycle.
- rvalid  out  1  one-cycle response strobe.
- rdata  out  32  load data; valid only when rvalid=1.
- err  out  1  access fault, qualified by rvalid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ready=1, rvalid=0, rdata=0, err=0, counter=0.
- Reset does not clear RAM contents.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - ready=1.
  - Acceptance occurs when req=1 and ready=1 on a rising edge. we, addr and wdata are captured into holding registers.
  - After acceptance: if LATENCY=0, go to RESP; otherwise load cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - ready=0; req is ignored.
  - If cnt=0, go to RESP; otherwise decrement cnt.
- RESP:
  - ready=0, rvalid=1 for exactly one cycle, then return to IDLE.
- Total latency: rvalid rises LATENCY+1 cycles after the acceptance edge.
- Maximum throughput: one request per LATENCY+2 cycles.
- Address decoding:
  - Word index is addr[DEPTH_LOG2+1:2].
  - Fault (err=1) if addr[1:0]≠0, or if any of addr[31:DEPTH_LOG2+2]≠0.
- Store:
  - The RAM write commits on the edge that enters RESP, and only if there is no fault.
  - rvalid=1 acknowledges the store; rdata=0.
- Load: rdata is the RAM word at the captured index, registered so that it appears together with rvalid; rdata=0 on a fault.
- Faulted store: no write is performed; err=1, rvalid=1.
- err and rdata return to 0 whenever rvalid=0.
- req asserted while ready=0 has no effect. The CPU must hold req until it sees ready=1 at a clock edge.
- Changes to addr, we or wdata after acceptance do not affect the outstanding access.
- Reset asserted in WAIT or RESP aborts the access:
  - A pending store never commits if Reset arrives before the RESP-entry edge.
  - No rvalid is produced for an aborted access.
- Load immediately after a store to the same address returns the new data.

Decomposition:
- Shared package mem_pkg holds:
  - the state encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10;
  - the word width constant (32) and the byte-offset width (2);
  - a fault-check function (addr, DEPTH_LOG2) → err.
- One natural sub-module: mem_array, a single-port synchronous RAM with write enable, DEPTH_LOG2 address bits and 32-bit data. The responder FSM, counter and holding registers stay in data_mem_responder.

Test Plan:
- Reset with req=0 → ready=1, rvalid=0, rdata=0, err=0 immediately (asynchronous), and these values hold after Reset deasserts.
- Store 0xDEADBEEF to addr 0x10 at LATENCY=2, then load from 0x10 → store ack: rvalid high exactly 3 cycles after acceptance with err=0; load: rdata=0xDEADBEEF, err=0; ready=0 for 3 cycles per access.
- Load from addr 0x13 (misaligned) and from 0x400 (out of range at DEPTH_LOG2=8) → rvalid=1, err=1, rdata=0. A store to 0x400 leaves word 0 unchanged when read back.
- Back-to-back: req held high continuously with loads from 0x0, 0x4, 0x8 → acceptances 4 cycles apart, each rvalid a single cycle, rdata in request order.
- Store 0x12345678 to 0x20, with Reset pulsed in the WAIT state → no rvalid; after reset, a load from 0x20 returns the previous contents, not 0x12345678.
- LATENCY=0 build: load request → rvalid on the cycle after acceptance; ready back to 1 in the cycle following rvalid.
